mem_loader: RTL and testbench
=============================

# mem_loader

Boot-time program/data loader: writer end of the memory port the fetcher reads from. Accepts a byte stream over a valid/ready handshake, writes it to consecutive memory addresses, reads the region back to verify an 8-bit checksum, then releases the core from reset. It replaces manual pre-loading of memory: memory is filled outside chip logic while the core is held in reset.

## Interface
- ADDR_WIDTH, default `ADDR_WIDTH, memory address width
- DATA_WIDTH, default `REG_WIDTH (8), byte width
- DEPTH, default 32, number of valid memory locations
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; begins a load using base_addr/length
- base_addr  in  ADDR_WIDTH  first address written
- length  in  ADDR_WIDTH  byte count; 0 is legal
- s_valid  in  1  source byte valid
- s_data  in  DATA_WIDTH  source byte
- s_ready  out  1  loader accepts byte this cycle
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_din  out  DATA_WIDTH  write data
- mem_dout  in  DATA_WIDTH  read data, valid the cycle after mem_addr is presented with mem_we=0
- busy  out  1  load or verify in progress
- done  out  1  level; last load verified OK
- error  out  1  level; last load failed (range or checksum)
- cpu_reset_n  out  1  core reset; low until a load completes successfully

## Operation
- States: IDLE, LOAD, VERIFY, CHECK, DONE, ERROR.
- IDLE: s_ready=0. On start: latch base/length, clear sum, clear done/error, drive cpu_reset_n=0. Range check: if base_addr+length > DEPTH (computed at ADDR_WIDTH+1 bits), go to ERROR with no write; if length==0, go to DONE; else go to LOAD.
- LOAD: s_ready=1. Each s_valid&&s_ready accepts one byte: next cycle mem_we=1, mem_addr=base+k, mem_din=byte; sum += byte (mod 2^DATA_WIDTH). Gaps in s_valid hold mem_we=0. After byte length-1 is accepted, s_ready drops the next cycle and the state goes to VERIFY once the final write has been issued.
- VERIFY: mem_we=0; mem_addr=base+j for j=0..length-1, one per cycle; readback sum accumulates mem_dout one cycle behind. After the final read, go to CHECK.
- CHECK: one cycle; compare readback sum with write sum; match -> DONE, mismatch -> ERROR.
- DONE: done=1, busy=0, cpu_reset_n=1. ERROR: error=1, busy=0, cpu_reset_n=0. Both accept start, behaving as IDLE.
- start while busy is ignored. s_valid outside LOAD is ignored; no byte is consumed.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, error=0, cpu_reset_n=0, state=IDLE, both sums 0.
- All outputs are registered; no combinational path from s_valid to s_ready.
- Throughput: 1 byte/cycle in LOAD and in VERIFY.
- Latency, start to done with continuous s_valid: length (load) + 1 (last write) + length (reads) + 1 (last data) + 1 (CHECK).
- length==0: done rises the cycle after start. Range error: error rises the cycle after start, with no mem_we pulse.
- Address arithmetic is modulo 2^ADDR_WIDTH internally. The range check guarantees no wrap past DEPTH.
- Reset mid-operation: immediate return to reset values. The partially written memory is not cleaned. cpu_reset_n stays low.

## Structure
- pkg.v: state encoding (`LDR_IDLE..`LDR_ERROR). Reuses `ADDR_WIDTH/`REG_WIDTH.
- One sub-module, byte_summer: clear, enable, DATA_WIDTH byte in, registered modular sum out. It is instantiated twice, once for writes and once for readback.

## Test plan
- 16 random bytes (seed 33551), base 0, length 16, continuous valid -> mem[0..15] match, done=1 exactly 35 cycles after start, cpu_reset_n=1.
- Program A9 04 85 02, base 0x10, length 4, s_valid low every other cycle -> mem[0x10..0x13]=A9,04,85,02; no mem_we during gaps; done=1.
- Bench overwrites mem[0x11] with 0xFF after the LOAD write but before its VERIFY read -> error=1, done=0, cpu_reset_n=0.
- base 0x1E, length 4, DEPTH 32 -> error=1 next cycle, mem_we never asserted, s_ready never asserted.
- length 0 -> done=1 next cycle, no mem activity. Start while busy -> ignored, original load completes.
- reset pulsed after 3 of 8 bytes are accepted -> all outputs at reset values; a following start with length 8 completes with done=1.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared widths and state encoding for the boot-time memory loader.
package mem_loader_pkg;

  localparam int unsigned LDR_ADDR_WIDTH = 8;
  localparam int unsigned LDR_REG_WIDTH  = 8;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_LOAD,
    LDR_VERIFY,
    LDR_CHECK,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_t;

endpackage

// File: rtl/mem_loader_byte_summer.sv
// Registered modular byte accumulator; clear takes priority over enable.
module byte_summer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] sum
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       sum <= '0;
    else if (clear)  sum <= '0;
    else if (enable) sum <= sum + din;
  end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: streams bytes into memory, reads the region back to verify a
// checksum, then releases the core from reset.
module mem_loader #(
  parameter int unsigned ADDR_WIDTH = mem_loader_pkg::LDR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = mem_loader_pkg::LDR_REG_WIDTH,
  parameter int unsigned DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_reset_n
);
  import mem_loader_pkg::*;

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  ldr_state_t            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  rd_issued;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] wr_sum;
  logic [DATA_WIDTH-1:0] rd_sum;
  logic                  launch;
  logic                  accept;
  logic                  rd_en;
  logic [ADDR_WIDTH:0]   range_end;

  always_comb begin
    launch    = start && ((state == LDR_IDLE) || (state == LDR_DONE) || (state == LDR_ERROR));
    accept    = (state == LDR_LOAD) && s_valid && s_ready;
    rd_en     = (state == LDR_VERIFY) && rd_valid;
    range_end = {1'b0, base_addr} + {1'b0, length};
  end

  byte_summer #(.DATA_WIDTH(DATA_WIDTH)) u_wr_sum (
    .clk    (clk),
    .reset  (reset),
    .clear  (launch),
    .enable (accept),
    .din    (s_data),
    .sum    (wr_sum)
  );

  byte_summer #(.DATA_WIDTH(DATA_WIDTH)) u_rd_sum (
    .clk    (clk),
    .reset  (reset),
    .clear  (launch),
    .enable (rd_en),
    .din    (mem_dout),
    .sum    (rd_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LDR_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      rd_issued   <= 1'b0;
      rd_valid    <= 1'b0;
      s_ready     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      // rd_issued: address on the bus this cycle; rd_valid: its data on mem_dout.
      rd_valid <= rd_issued;
      case (state)
        LDR_IDLE, LDR_DONE, LDR_ERROR: begin
          if (start) begin
            base_q      <= base_addr;
            len_q       <= length;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            rd_issued   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
            if (range_end > DEPTH_LIM) begin
              state <= LDR_ERROR;
              error <= 1'b1;
            end else if (length == '0) begin
              state       <= LDR_DONE;
              done        <= 1'b1;
              cpu_reset_n <= 1'b1;
            end else begin
              state   <= LDR_LOAD;
              s_ready <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        LDR_LOAD: begin
          if (accept) begin
            mem_we   <= 1'b1;
            mem_addr <= base_q + wr_cnt;
            mem_din  <= s_data;
            wr_cnt   <= wr_cnt + 1'b1;
            if (wr_cnt == len_q - 1'b1) s_ready <= 1'b0;
          end else if (!s_ready) begin
            // Final write is on the bus this cycle; first read address follows it.
            state     <= LDR_VERIFY;
            mem_addr  <= base_q;
            rd_cnt    <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            rd_issued <= 1'b1;
          end
        end
        LDR_VERIFY: begin
          if (rd_cnt != len_q) begin
            mem_addr  <= base_q + rd_cnt;
            rd_cnt    <= rd_cnt + 1'b1;
            rd_issued <= 1'b1;
          end else begin
            rd_issued <= 1'b0;
            if (!rd_issued && rd_valid) state <= LDR_CHECK;
          end
        end
        LDR_CHECK: begin
          busy <= 1'b0;
          if (wr_sum == rd_sum) begin
            state       <= LDR_DONE;
            done        <= 1'b1;
            cpu_reset_n <= 1'b1;
          end else begin
            state <= LDR_ERROR;
            error <= 1'b1;
          end
        end
        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a synchronous-read memory model.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] length;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       busy;
  logic       done;
  logic       error;
  logic       cpu_reset_n;

  logic [7:0] mem [0:255];
  logic       poke_en;
  logic [7:0] poke_addr;
  logic [7:0] poke_data;
  logic [7:0] src [0:15];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_reset_n (cpu_reset_n)
  );

  // Poke is applied after the loader write so it wins on a shared address.
  always @(posedge clk) begin
    if (mem_we)  mem[mem_addr] <= mem_din;
    if (poke_en) mem[poke_addr] <= poke_data;
    mem_dout <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, " s_ready"},     32'(s_ready),     32'h0);
    check({pfx, " mem_we"},      32'(mem_we),      32'h0);
    check({pfx, " mem_addr"},    32'(mem_addr),    32'h0);
    check({pfx, " mem_din"},     32'(mem_din),     32'h0);
    check({pfx, " busy"},        32'(busy),        32'h0);
    check({pfx, " done"},        32'(done),        32'h0);
    check({pfx, " error"},       32'(error),       32'h0);
    check({pfx, " cpu_reset_n"}, 32'(cpu_reset_n), 32'h0);
  endtask

  // lat = clock edges after the start-sampling edge until done/error shows (-1 on timeout).
  task automatic run_load(input logic [7:0] b, input logic [7:0] len, input int nbytes,
                          input bit gaps, input int restart_at, input int abort_after,
                          output int lat, output int stray_we, output int n_we);
    int k; int cyc; bit phase; bit acc; bit prev_acc;
    k = 0; cyc = 0; phase = 1'b1; prev_acc = 1'b0; stray_we = 0; n_we = 0; lat = -1;
    @(negedge clk);
    start = 1'b1; base_addr = b; length = len;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 400) begin
      if (done || error) begin lat = cyc; break; end
      if (abort_after >= 0 && k == abort_after) break;
      if (mem_we) n_we++;
      if (mem_we && !prev_acc) stray_we++;
      start = (cyc == restart_at);
      if (start) begin base_addr = 8'h1E; length = 8'h04; end
      s_valid = (k < nbytes) && (!gaps || phase);
      s_data  = (k < nbytes) ? src[k] : 8'h00;
      acc = s_valid && s_ready;
      @(negedge clk);
      cyc++; phase = !phase; prev_acc = acc;
      if (acc) k++;
    end
    s_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    int lat; int stray; int nwe; int bad;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    s_valid = 1'b0; s_data = '0; poke_en = 1'b0; poke_addr = 8'h11; poke_data = 8'hFF;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    // 16 random bytes, continuous valid; a second start mid-load must be ignored.
    void'($urandom(33551));
    for (int i = 0; i < 16; i++) src[i] = 8'($urandom());
    run_load(8'h00, 8'd16, 16, 1'b0, 5, -1, lat, stray, nwe);
    check("t1 latency", 32'(lat), 32'd35);
    check("t1 done", 32'(done), 32'h1);
    check("t1 error", 32'(error), 32'h0);
    check("t1 cpu_reset_n", 32'(cpu_reset_n), 32'h1);
    check("t1 busy", 32'(busy), 32'h0);
    check("t1 writes", 32'(nwe), 32'd16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== src[i]) bad++;
    check("t1 mem contents", 32'(bad), 32'd0);

    // Four-byte program with a gap every other cycle.
    src[0] = 8'hA9; src[1] = 8'h04; src[2] = 8'h85; src[3] = 8'h02;
    run_load(8'h10, 8'd4, 4, 1'b1, -1, -1, lat, stray, nwe);
    check("t2 done", 32'(done), 32'h1);
    check("t2 writes", 32'(nwe), 32'd4);
    check("t2 gap writes", 32'(stray), 32'd0);
    check("t2 mem10", 32'(mem[8'h10]), 32'hA9);
    check("t2 mem11", 32'(mem[8'h11]), 32'h04);
    check("t2 mem12", 32'(mem[8'h12]), 32'h85);
    check("t2 mem13", 32'(mem[8'h13]), 32'h02);

    // Range error: 0x1E + 4 > 32.
    run_load(8'h1E, 8'd4, 4, 1'b0, -1, -1, lat, stray, nwe);
    check("t4 latency", 32'(lat), 32'd0);
    check("t4 error", 32'(error), 32'h1);
    check("t4 done", 32'(done), 32'h0);
    check("t4 cpu_reset_n", 32'(cpu_reset_n), 32'h0);
    bad = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (s_ready || mem_we) bad++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("t4 no ready/we", 32'(bad), 32'd0);

    // Zero length completes the cycle after start.
    run_load(8'h05, 8'd0, 0, 1'b0, -1, -1, lat, stray, nwe);
    check("t5 latency", 32'(lat), 32'd0);
    check("t5 done", 32'(done), 32'h1);
    check("t5 error", 32'(error), 32'h0);
    check("t5 cpu_reset_n", 32'(cpu_reset_n), 32'h1);
    check("t5 mem_we", 32'(mem_we), 32'h0);
    check("t5 busy", 32'(busy), 32'h0);

    // Corrupt mem[0x11] between its write and its readback.
    poke_en = 1'b1;
    run_load(8'h10, 8'd4, 4, 1'b0, -1, -1, lat, stray, nwe);
    poke_en = 1'b0;
    check("t3 error", 32'(error), 32'h1);
    check("t3 done", 32'(done), 32'h0);
    check("t3 cpu_reset_n", 32'(cpu_reset_n), 32'h0);
    check("t3 latency", 32'(lat), 32'd11);

    // Reset after three of eight bytes, then a clean reload.
    for (int i = 0; i < 8; i++) src[i] = 8'(8'h11 * (i + 1));
    run_load(8'h08, 8'd8, 8, 1'b0, -1, 3, lat, stray, nwe);
    reset = 1'b1;
    #1;
    check_reset_vals("t6 midreset");
    @(negedge clk);
    reset = 1'b0;
    run_load(8'h08, 8'd8, 8, 1'b0, -1, -1, lat, stray, nwe);
    check("t6 done", 32'(done), 32'h1);
    check("t6 latency", 32'(lat), 32'd19);
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[8 + i] !== src[i]) bad++;
    check("t6 mem contents", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
